// File: rtl/req_arbiter_rr_if.sv
// Bundle of lane request/descriptor inputs and grant/descriptor outputs between the
// requesting lanes (master) and the round-robin access arbiter (slave).
interface req_arbiter_rr_if #(
  parameter int NUM_CH       = 4,
  parameter int WIDTH_ADDR   = 16,
  parameter int WIDTH_STRIDE = 16,
  parameter int WIDTH_NO     = $clog2(NUM_CH + 1)
);
  logic [NUM_CH-1:0]              I_Req;
  logic [NUM_CH-1:0]              I_Term;
  logic [NUM_CH*WIDTH_ADDR-1:0]   I_Length;
  logic [NUM_CH*WIDTH_STRIDE-1:0] I_Stride;
  logic [NUM_CH*WIDTH_ADDR-1:0]   I_Base_Addr;
  logic [NUM_CH-1:0]              O_Grant;
  logic                           O_GrantVld;
  logic [WIDTH_NO-1:0]            O_GrantNo;
  logic                           O_Req;
  logic [WIDTH_ADDR-1:0]          O_Length;
  logic [WIDTH_STRIDE-1:0]        O_Stride;
  logic [WIDTH_ADDR-1:0]          O_Base_Addr;
  logic                           O_Timeout;

  modport master (
    output I_Req, I_Term, I_Length, I_Stride, I_Base_Addr,
    input  O_Grant, O_GrantVld, O_GrantNo, O_Req, O_Length, O_Stride, O_Base_Addr, O_Timeout
  );

  modport slave (
    input  I_Req, I_Term, I_Length, I_Stride, I_Base_Addr,
    output O_Grant, O_GrantVld, O_GrantNo, O_Req, O_Length, O_Stride, O_Base_Addr, O_Timeout
  );
endinterface

// File: rtl/req_arbiter_rr.sv
// N-lane round-robin arbiter in front of the DMem access manager; latches the winner's
// descriptor at grant time. Optional grant watchdog enabled by REQ_ARBITER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant; pick next requester after the RR pointer
// GRANT | one lane owns the manager until its Term (or watchdog expiry)
module req_arbiter_rr #(
  parameter int NUM_CH         = 4,
  parameter int WIDTH_ADDR     = 16,
  parameter int WIDTH_STRIDE   = 16,
  parameter int WIDTH_NO       = $clog2(NUM_CH + 1),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clock,
  input  logic           reset,
  req_arbiter_rr_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_CH - 1);

  if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
    $error("req_arbiter_rr: NUM_CH out of range");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("req_arbiter_rr: TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q;
  logic [NUM_CH-1:0]       grant_q;
  logic [WIDTH_NO-1:0]     grant_no_q;
  logic                    req_q;
  logic [WIDTH_ADDR-1:0]   length_q;
  logic [WIDTH_STRIDE-1:0] stride_q;
  logic [WIDTH_ADDR-1:0]   base_q;

  logic                    found;
  logic [IDX_W-1:0]        win_idx;
  logic                    term_hit;
  logic                    tmo_hit;
  logic                    load;
  logic                    release_g;

  // Search starts just after the last winner so every lane gets a turn.
  always_comb begin
    int cand;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!found && bus.I_Req[cand]) begin
        found   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

  assign term_hit = |(bus.I_Term & grant_q);

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    release_g = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          load    = 1'b1;
        end
      end
      GRANT: begin
        if (term_hit || tmo_hit) begin
          state_d   = IDLE;
          release_g = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q      <= PTR_RST;
      grant_q    <= '0;
      grant_no_q <= '0;
      req_q      <= 1'b0;
      length_q   <= '0;
      stride_q   <= '0;
      base_q     <= '0;
    end else begin
      req_q <= load;
      if (load) begin
        ptr_q      <= win_idx;
        grant_q    <= NUM_CH'(1) << win_idx;
        grant_no_q <= WIDTH_NO'(win_idx) + 1'b1;
        length_q   <= bus.I_Length[win_idx*WIDTH_ADDR +: WIDTH_ADDR];
        stride_q   <= bus.I_Stride[win_idx*WIDTH_STRIDE +: WIDTH_STRIDE];
        base_q     <= bus.I_Base_Addr[win_idx*WIDTH_ADDR +: WIDTH_ADDR];
      end else if (release_g) begin
        grant_q    <= '0;
        grant_no_q <= '0;
        length_q   <= '0;
        stride_q   <= '0;
        base_q     <= '0;
      end
    end
  end

`ifdef REQ_ARBITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_q;

  // A Term in the expiry cycle wins, so no spurious watchdog pulse.
  assign tmo_hit = (state_q == GRANT) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit && !term_hit;
      if (load)                  tmo_cnt_q <= '0;
      else if (state_q == GRANT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign bus.O_Timeout = timeout_q;
`else
  assign tmo_hit       = 1'b0;
  assign bus.O_Timeout = 1'b0;
`endif

  assign bus.O_Grant     = grant_q;
  assign bus.O_GrantVld  = |grant_q;
  assign bus.O_GrantNo   = grant_no_q;
  assign bus.O_Req       = req_q;
  assign bus.O_Length    = length_q;
  assign bus.O_Stride    = stride_q;
  assign bus.O_Base_Addr = base_q;

endmodule

// File: tb/tb_req_arbiter_rr.sv
// Directed vector bench for req_arbiter_rr: RR table plus hand sequences for descriptor
// hold, foreign Term, async reset and (with REQ_ARBITER_TIMEOUT_EN) the watchdog.
module tb_req_arbiter_rr;

  localparam int NCH = 4;
  localparam int WA  = 16;
  localparam int WS  = 16;
  localparam int WN  = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  req_arbiter_rr_if #(.NUM_CH(NCH), .WIDTH_ADDR(WA), .WIDTH_STRIDE(WS), .WIDTH_NO(WN)) bus ();

  req_arbiter_rr #(
    .NUM_CH(NCH), .WIDTH_ADDR(WA), .WIDTH_STRIDE(WS), .WIDTH_NO(WN), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] req;
    logic [3:0] term;
    logic [3:0] grant;
    logic [2:0] no;
    logic       oreq;
  } vec_t;

  vec_t vecs [26];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] status();
    return {bus.O_Grant, bus.O_GrantVld, bus.O_GrantNo, bus.O_Req, bus.O_Timeout};
  endfunction

  function automatic logic [9:0] expect_st(logic [3:0] g, logic [2:0] no, logic oreq, logic tmo);
    return {g, |g, no, oreq, tmo};
  endfunction

  initial begin
    vecs[0]  = '{4'hF, 4'h0, 4'b0001, 3'd1, 1'b1};
    vecs[1]  = '{4'hF, 4'h2, 4'b0001, 3'd1, 1'b0};
    vecs[2]  = '{4'hF, 4'h0, 4'b0001, 3'd1, 1'b0};
    vecs[3]  = '{4'hF, 4'h1, 4'b0000, 3'd0, 1'b0};
    vecs[4]  = '{4'hF, 4'h0, 4'b0010, 3'd2, 1'b1};
    vecs[5]  = '{4'hF, 4'h0, 4'b0010, 3'd2, 1'b0};
    vecs[6]  = '{4'hF, 4'h0, 4'b0010, 3'd2, 1'b0};
    vecs[7]  = '{4'hF, 4'h2, 4'b0000, 3'd0, 1'b0};
    vecs[8]  = '{4'hF, 4'h0, 4'b0100, 3'd3, 1'b1};
    vecs[9]  = '{4'hF, 4'h0, 4'b0100, 3'd3, 1'b0};
    vecs[10] = '{4'hF, 4'h0, 4'b0100, 3'd3, 1'b0};
    vecs[11] = '{4'hF, 4'h4, 4'b0000, 3'd0, 1'b0};
    vecs[12] = '{4'hF, 4'h0, 4'b1000, 3'd4, 1'b1};
    vecs[13] = '{4'hF, 4'h0, 4'b1000, 3'd4, 1'b0};
    vecs[14] = '{4'hF, 4'h0, 4'b1000, 3'd4, 1'b0};
    vecs[15] = '{4'hF, 4'h8, 4'b0000, 3'd0, 1'b0};
    vecs[16] = '{4'hF, 4'h0, 4'b0001, 3'd1, 1'b1};
    vecs[17] = '{4'hF, 4'h1, 4'b0000, 3'd0, 1'b0};
    vecs[18] = '{4'h1, 4'h0, 4'b0001, 3'd1, 1'b1};
    vecs[19] = '{4'h1, 4'h1, 4'b0000, 3'd0, 1'b0};
    vecs[20] = '{4'h0, 4'h0, 4'b0000, 3'd0, 1'b0};
    vecs[21] = '{4'h5, 4'h0, 4'b0100, 3'd3, 1'b1};
    vecs[22] = '{4'h5, 4'h4, 4'b0000, 3'd0, 1'b0};
    vecs[23] = '{4'h5, 4'h0, 4'b0001, 3'd1, 1'b1};
    vecs[24] = '{4'h0, 4'h1, 4'b0000, 3'd0, 1'b0};
    vecs[25] = '{4'h0, 4'h0, 4'b0000, 3'd0, 1'b0};

    bus.I_Req       = '0;
    bus.I_Term      = '0;
    bus.I_Length    = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    bus.I_Stride    = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    bus.I_Base_Addr = {16'h4000, 16'h3000, 16'h2000, 16'h1000};

    step();
    step();
    chk("reset_status", 64'(status()), 64'(expect_st(4'b0, 3'd0, 1'b0, 1'b0)));
    chk("reset_desc", 64'({bus.O_Length, bus.O_Stride, bus.O_Base_Addr}), 64'd0);
    reset = 1'b1;

    // Round-robin, ignored foreign Term, Term in the O_Req cycle, pointer rotation.
    for (int i = 0; i < 26; i++) begin
      bus.I_Req  = vecs[i].req;
      bus.I_Term = vecs[i].term;
      step();
      chk($sformatf("vec%0d", i), 64'(status()),
          64'(expect_st(vecs[i].grant, vecs[i].no, vecs[i].oreq, 1'b0)));
    end

    // Descriptor captured at grant and held while the lane's inputs change.
    bus.I_Length    = {16'h0004, 16'h0040, 16'h0002, 16'h0001};
    bus.I_Stride    = {16'h0040, 16'h0003, 16'h0020, 16'h0010};
    bus.I_Base_Addr = {16'h4000, 16'h1234, 16'h2000, 16'h1000};
    bus.I_Req  = 4'b0100;
    bus.I_Term = 4'b0000;
    step();
    chk("desc_grant", 64'(status()), 64'(expect_st(4'b0100, 3'd3, 1'b1, 1'b0)));
    chk("desc_capture", 64'({bus.O_Length, bus.O_Stride, bus.O_Base_Addr}), 64'h0040_0003_1234);
    bus.I_Length    = {16'h0004, 16'hAAAA, 16'h0002, 16'h0001};
    bus.I_Stride    = {16'h0040, 16'h5555, 16'h0020, 16'h0010};
    bus.I_Base_Addr = {16'h4000, 16'hBEEF, 16'h2000, 16'h1000};
    bus.I_Req  = 4'b0000;
    step();
    chk("desc_hold1", 64'({bus.O_Length, bus.O_Stride, bus.O_Base_Addr}), 64'h0040_0003_1234);
    step();
    chk("desc_hold2", 64'({bus.O_Length, bus.O_Stride, bus.O_Base_Addr}), 64'h0040_0003_1234);
    chk("desc_grant_held", 64'(status()), 64'(expect_st(4'b0100, 3'd3, 1'b0, 1'b0)));
    bus.I_Term = 4'b0100;
    step();
    bus.I_Term = 4'b0000;
    chk("desc_release", 64'({bus.O_Length, bus.O_Stride, bus.O_Base_Addr}), 64'd0);
    chk("desc_release_st", 64'(status()), 64'(expect_st(4'b0, 3'd0, 1'b0, 1'b0)));

    // Only the granted lane's Term releases; dropping its request does not.
    bus.I_Req = 4'b0001;
    step();
    chk("own_grant", 64'(status()), 64'(expect_st(4'b0001, 3'd1, 1'b1, 1'b0)));
    bus.I_Req  = 4'b0000;
    bus.I_Term = 4'b0010;
    step();
    chk("own_foreign_term", 64'(status()), 64'(expect_st(4'b0001, 3'd1, 1'b0, 1'b0)));
    bus.I_Term = 4'b0000;
    step();
    chk("own_req_dropped", 64'(status()), 64'(expect_st(4'b0001, 3'd1, 1'b0, 1'b0)));
    bus.I_Term = 4'b0001;
    step();
    bus.I_Term = 4'b0000;
    chk("own_release", 64'(status()), 64'(expect_st(4'b0, 3'd0, 1'b0, 1'b0)));

    // Asynchronous reset in the middle of a grant with a Term pending.
    bus.I_Req = 4'b1000;
    step();
    chk("arst_pre", 64'(status()), 64'(expect_st(4'b1000, 3'd4, 1'b1, 1'b0)));
    bus.I_Term = 4'b1000;
    #2 reset = 1'b0;
    #1;
    chk("arst_status", 64'(status()), 64'(expect_st(4'b0, 3'd0, 1'b0, 1'b0)));
    chk("arst_desc", 64'({bus.O_Length, bus.O_Stride, bus.O_Base_Addr}), 64'd0);
    step();
    reset      = 1'b1;
    bus.I_Term = 4'b0000;
    bus.I_Req  = 4'b1001;
    step();
    chk("arst_ptr", 64'(status()), 64'(expect_st(4'b0001, 3'd1, 1'b1, 1'b0)));
    bus.I_Req  = 4'b0000;
    bus.I_Term = 4'b0001;
    step();
    bus.I_Term = 4'b0000;
    chk("arst_release", 64'(status()), 64'(expect_st(4'b0, 3'd0, 1'b0, 1'b0)));

`ifdef REQ_ARBITER_TIMEOUT_EN
    // Lane 1 never terminates: watchdog releases 8 cycles after grant, lane 2 goes next.
    bus.I_Req = 4'b0010;
    step();
    chk("tmo_grant", 64'(status()), 64'(expect_st(4'b0010, 3'd2, 1'b1, 1'b0)));
    bus.I_Req = 4'b0110;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k < 8)
        chk($sformatf("tmo_hold%0d", k), 64'(status()), 64'(expect_st(4'b0010, 3'd2, 1'b0, 1'b0)));
      else
        chk("tmo_pulse", 64'(status()), 64'(expect_st(4'b0, 3'd0, 1'b0, 1'b1)));
    end
    step();
    chk("tmo_next", 64'(status()), 64'(expect_st(4'b0100, 3'd3, 1'b1, 1'b0)));
    bus.I_Req  = 4'b0000;
    bus.I_Term = 4'b0100;
    step();
    bus.I_Term = 4'b0000;
    chk("tmo_final", 64'(status()), 64'(expect_st(4'b0, 3'd0, 1'b0, 1'b0)));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/req_arbiter_rr.md
Name: req_arbiter_rr

Overview:
- Parametrised N-channel access arbiter in front of the DMem access manager; generalises the fixed 3-lane request handler.
- Round-robin fairness instead of first-come lockout; the winner's Length/Stride/Base descriptor is registered at grant time.
- Issues a one-cycle request pulse to the manager and holds the grant until the granted lane signals end of access.

Parameters:
- NUM_CH, 4, number of requesting lanes (2..16).
- WIDTH_ADDR, 16, width of Length and Base_Addr fields.
- WIDTH_STRIDE, 16, width of Stride field.
- WIDTH_NO, $clog2(NUM_CH+1), width of O_GrantNo.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- I_Req  in  NUM_CH  per-lane access request (level).
- I_Term  in  NUM_CH  per-lane end of access (pulse).
- I_Length  in  NUM_CH*WIDTH_ADDR  per-lane access length; lane i occupies slice i.
- I_Stride  in  NUM_CH*WIDTH_STRIDE  per-lane stride factor.
- I_Base_Addr  in  NUM_CH*WIDTH_ADDR  per-lane base address.
- O_Grant  out  NUM_CH  one-hot grant to lanes.
- O_GrantVld  out  1  any grant active.
- O_GrantNo  out  WIDTH_NO  granted lane index+1; 0 = none.
- O_Req  out  1  one-cycle access request pulse to the manager.
- O_Length  out  WIDTH_ADDR  latched length of the granted lane.
- O_Stride  out  WIDTH_STRIDE  latched stride of the granted lane.
- O_Base_Addr  out  WIDTH_ADDR  latched base address of the granted lane.
- O_Timeout  out  1  watchdog forced-release pulse; tied 0 without the macro.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; RR pointer = NUM_CH-1, so lane 0 has top priority first.
- FSM has two states, IDLE and GRANT.
- IDLE: if I_Req != 0, pick the first requesting lane searching from pointer+1 upward, wrapping modulo NUM_CH.
  - Next edge: state GRANT, O_Grant[w]=1, O_GrantNo=w+1, O_GrantVld=1.
  - Descriptors of lane w are captured into the O_Length/O_Stride/O_Base_Addr registers; pointer = w.
  - O_Req = 1 for exactly this first GRANT cycle.
- Latency: I_Req rising in IDLE at cycle t gives grant and O_Req at t+1.
- GRANT: grant and descriptors are held stable.
  - Only I_Term[w] of the granted lane is honoured; I_Term of other lanes is ignored.
  - Dropping I_Req[w] while granted does not release the grant.
  - I_Term[w] at cycle t: state IDLE at t+1, with O_Grant, O_GrantVld and O_GrantNo all 0. Descriptor outputs return to 0.
  - The earliest next grant is t+2, so there is at least one idle cycle between grants.
- I_Term[w] in the same cycle as the O_Req pulse is legal and releases normally.
- Inputs sampled in GRANT never change the winner. Pending requests are serviced in RR order after release.
- Fairness: with all lanes requesting continuously, grants follow 0,1,...,NUM_CH-1,0,...
- No request storage: a lane that drops I_Req before it is granted is lost.
- O_GrantVld = |O_Grant. At most one O_Grant bit is ever set.
- Asynchronous reset mid-GRANT immediately clears the grant and descriptors and returns the pointer to NUM_CH-1; a pending Term is discarded.

Optional Feature:
- Macro REQ_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on grant and increments each GRANT cycle.
  - When it reaches TIMEOUT_CYCLES without I_Term[w], the FSM returns to IDLE and O_Timeout pulses for 1 cycle, coincident with the grant dropping.
  - The pointer stays at w, so the offender has lowest priority next.
- Not defined: no counter; O_Timeout is constant 0; the grant is held indefinitely.

Test Plan:
- Reset, then I_Req=4'b1111 held; terminate each grant 3 cycles later -> O_GrantNo sequence 1,2,3,4,1; one O_Req pulse per grant; one idle cycle between grants.
- I_Req=4'b0100, I_Base_Addr lane2=0x1234, then change lane2 descriptors while granted -> O_Base_Addr stays 0x1234 until Term, then 0.
- Granted lane 0; pulse I_Term[1] and drop I_Req[0] -> grant to lane 0 held; only I_Term[0] releases it.
- I_Req=4'b0001 with I_Term[0] asserted in the grant cycle -> grant 1 cycle, O_Req 1 cycle, IDLE next cycle.
- Assert reset low mid-grant on lane 3 -> outputs 0 asynchronously; after release with I_Req=4'b1001, lane 0 is granted first.
- With REQ_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8, grant lane 1 and never terminate -> O_Timeout pulses 8 cycles after grant; next grant goes to lane 2 if it is requesting.
